// File: rtl/fifo_n.sv
// fifo_n: WIDTH x DEPTH circular-buffer queue with guarded enq/deq/first methods and occupancy count.
// Latency: one cycle enq-to-first (no bypass); first is a combinational read of the head slot.
// Backpressure: in_enq__RDY low when full, out_deq__RDY/out_first__RDY low when empty.
// Optional: define FIFO_N_PIPELINE_EN to accept an enq while full when a deq happens in the same cycle.
module fifo_n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  output logic [CNTW-1:0]  count
);

  // Pointer width; DEPTH >= 2 so this is at least one bit.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rp;
  logic [PW-1:0]    wp;
  logic [CNTW-1:0]  cnt;
  logic             not_full;
  logic             not_empty;
  logic             enq_fire;
  logic             deq_fire;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from the count alone; pointer equality is ambiguous.
  assign not_full  = (cnt != FULL_CNT);
  assign not_empty = (cnt != '0);

`ifdef FIFO_N_PIPELINE_EN
  // A deq this cycle frees the head slot, so a full queue may still accept.
  assign in_enq__RDY = not_full | out_deq__ENA;
`else
  assign in_enq__RDY = not_full;
`endif
  assign out_deq__RDY   = not_empty;
  assign out_first__RDY = not_empty;
  assign out_first      = mem[rp];
  assign count          = cnt;

  assign enq_fire = in_enq__ENA & in_enq__RDY;
  assign deq_fire = out_deq__ENA & out_deq__RDY;

  // Pointer and occupancy update; simultaneous enq+deq leaves count unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (enq_fire) wp <= ptr_next(wp);
      if (deq_fire) rp <= ptr_next(rp);
      if (enq_fire && !deq_fire)
        cnt <= cnt + 1'b1;
      else if (deq_fire && !enq_fire)
        cnt <= cnt - 1'b1;
    end
  end

  // Storage write; contents are not reset, and writes are suppressed during reset.
  always_ff @(posedge CLK) begin
    if (!RST && enq_fire)
      mem[wp] <= in_enq_v;
  end

endmodule
